// File: rtl/text_pixel_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : text_pixel_gen_if
// Brief   : Pixel stream (valid/ready) and FontRom bus between the text raster
//           engine (master) and its surroundings (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface text_pixel_gen_if;
    logic        pix;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_eol;
    logic        pix_last;
    logic [13:0] font_ad;
    logic        font_ce;
    logic        font_oce;
    logic        font_dout;

    modport master (
        output pix, pix_valid, pix_eol, pix_last, font_ad, font_ce, font_oce,
        input  pix_ready, font_dout
    );

    modport slave (
        input  pix, pix_valid, pix_eol, pix_last, font_ad, font_ce, font_oce,
        output pix_ready, font_dout
    );
endinterface
`default_nettype wire

// File: rtl/text_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module  : text_pixel_gen
// Brief   : Text-mode raster engine; streams 1-bit pixels of a COLS x ROWS
//           character buffer by addressing FontRom. Optional CHAR_INVERT_EN
//           stores a per-cell reverse-video flag (txt_data[7]).
// Revision: 1.0 - initial release
// ============================================================================
module text_pixel_gen #(
    parameter  int COLS  = 16,
    parameter  int ROWS  = 4,
    localparam int CELLS = COLS * ROWS,
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  wire            clk,
    input  wire            reset,
    input  wire            txt_we,
    input  wire  [AW-1:0]  txt_addr,
    input  wire  [7:0]     txt_data,
    input  wire            start,
    output logic           busy,
    output logic           frame_done,
    text_pixel_gen_if.master pif
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef CHAR_INVERT_EN
    localparam int BW = 8;
`else
    localparam int BW = 7;
`endif

    localparam logic [1:0]    c_idle  = 2'd0;
    localparam logic [1:0]    c_run   = 2'd1;
    localparam logic [1:0]    c_drain = 2'd2;
    localparam logic [BW-1:0] c_space = BW'(32'h20);

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [3:0]    scan_q, scan_d;
    logic [CW-1:0] col_q, col_d;
    logic [2:0]    px_q, px_d;
    logic [BW-1:0] cbuf_q [CELLS];
    logic [BW-1:0] cbuf_d [CELLS];
    logic          pix_valid_q, pix_valid_d;
    logic          pix_eol_q, pix_eol_d;
    logic          pix_last_q, pix_last_d;
    logic          frame_done_q, frame_done_d;

    logic          w_advance;
    logic          w_ce;
    logic          w_accept;
    logic          w_eol;
    logic          w_last;
    logic [AW-1:0] w_cell;
    logic [BW-1:0] w_char;

    assign w_cell    = AW'(row_q) * AW'(COLS) + AW'(col_q);
    assign w_char    = cbuf_q[w_cell];
    assign w_advance = !pix_valid_q || pif.pix_ready;
    assign w_ce      = w_advance && ((state_q == c_run) ||
                                     ((state_q == c_drain) && pix_valid_q));
    assign w_accept  = pix_valid_q && pif.pix_ready;
    assign w_eol     = (col_q == CW'(COLS - 1)) && (px_q == 3'd7);
    assign w_last    = w_eol && (scan_q == 4'd15) && (row_q == RW'(ROWS - 1));

    // A write lands in the flop array, so a fetch in the same cycle sees the old code.
    always_comb begin
        cbuf_d = cbuf_q;
        if (txt_we && (int'(txt_addr) < CELLS)) begin
            cbuf_d[txt_addr] = txt_data[BW-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        row_d        = row_q;
        scan_d       = scan_q;
        col_d        = col_q;
        px_d         = px_q;
        case (state_q)
            c_idle: begin
                if (start) begin
                    state_d = c_run;
                    row_d   = '0;
                    scan_d  = '0;
                    col_d   = '0;
                    px_d    = '0;
                end
            end
            c_run: begin
                if (w_ce) begin
                    // Counters wrap naturally, so the frame ends with all of them at zero.
                    px_d = px_q + 3'd1;
                    if (px_q == 3'd7) begin
                        if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            if (scan_q == 4'd15) begin
                                scan_d = '0;
                                row_d  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                            end else begin
                                scan_d = scan_q + 4'd1;
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                    if (w_last) begin
                        state_d = c_drain;
                    end
                end
            end
            c_drain: begin
                if (w_accept) begin
                    state_d      = c_idle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        pix_valid_d = pix_valid_q;
        pix_eol_d   = pix_eol_q;
        pix_last_d  = pix_last_q;
        if (w_advance) begin
            if (state_q == c_run) begin
                pix_valid_d = 1'b1;
                pix_eol_d   = w_eol;
                pix_last_d  = w_last;
            end else begin
                pix_valid_d = 1'b0;
                pix_eol_d   = 1'b0;
                pix_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= c_idle;
            row_q        <= '0;
            scan_q       <= '0;
            col_q        <= '0;
            px_q         <= '0;
            pix_valid_q  <= 1'b0;
            pix_eol_q    <= 1'b0;
            pix_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                cbuf_q[i] <= c_space;
            end
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            scan_q       <= scan_d;
            col_q        <= col_d;
            px_q         <= px_d;
            pix_valid_q  <= pix_valid_d;
            pix_eol_q    <= pix_eol_d;
            pix_last_q   <= pix_last_d;
            frame_done_q <= frame_done_d;
            cbuf_q       <= cbuf_d;
        end
    end

`ifdef CHAR_INVERT_EN
    // Reverse-video flag travels with the address so it lines up with font_dout.
    logic inv_q, inv_d;

    always_comb begin
        inv_d = inv_q;
        if (w_advance) begin
            inv_d = (state_q == c_run) ? w_char[7] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign pif.pix = pif.font_dout ^ inv_q;
`else
    logic w_unused_inv;
    assign w_unused_inv = txt_data[7];
    assign pif.pix      = pif.font_dout;
`endif

    assign pif.pix_valid = pix_valid_q;
    assign pif.pix_eol   = pix_eol_q;
    assign pif.pix_last  = pix_last_q;
    assign pif.font_ad   = (state_q == c_idle) ? 14'd0 : {w_char[6:0], scan_q, px_q};
    assign pif.font_ce   = w_ce;
    assign pif.font_oce  = 1'b1;
    assign busy          = (state_q != c_idle);
    assign frame_done    = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_text_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_text_pixel_gen
// Brief   : Scoreboard bench for text_pixel_gen with a behavioural FontRom.
// Revision: 1.0 - initial release
// ============================================================================
module tb_text_pixel_gen;
    localparam int COLS     = 16;
    localparam int ROWS     = 4;
    localparam int CELLS    = COLS * ROWS;
    localparam int FRAME_PX = COLS * 8 * ROWS * 16;
`ifdef CHAR_INVERT_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       txt_we   = 1'b0;
    logic [5:0] txt_addr = '0;
    logic [7:0] txt_data = '0;
    logic       start    = 1'b0;
    logic       busy;
    logic       frame_done;

    text_pixel_gen_if u_if ();

    text_pixel_gen #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .txt_we     (txt_we),
        .txt_addr   (txt_addr),
        .txt_data   (txt_data),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .pif        (u_if.master)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         px_cnt = 0;
    int         fd_cnt = 0;
    int         fd_cyc = 0;
    int         last_px_cyc = 0;
    int         first_cyc = -1;
    bit         mon_en = 1'b0;
    logic [7:0] tb_buf [CELLS];
    logic [2:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural font: the space glyph is blank, everything else a fixed bit pattern.
    function automatic logic font_bit(input logic [13:0] a);
        if (a[13:7] == 7'h20) return 1'b0;
        return ^(a & 14'h1A6C) ^ a[0];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (u_if.font_ce) u_if.font_dout <= font_bit(u_if.font_ad);
    end

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            check("fd_after_last", cyc, last_px_cyc + 1);
        end
        if (mon_en && u_if.pix_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (u_if.pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("px_extra", 32'(px_cnt), 32'(FRAME_PX - 1));
                end else begin
                    check($sformatf("px%0d", px_cnt),
                          {29'd0, u_if.pix, u_if.pix_eol, u_if.pix_last}, {29'd0, exp_q.pop_front()});
                end
                if (u_if.pix_last) last_px_cyc = cyc;
                px_cnt++;
            end
        end
    end

    task automatic push_frame();
        logic [7:0]  code;
        logic [13:0] a;
        logic        p, eol, last;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int s = 0; s < 16; s++)
                for (int c = 0; c < COLS; c++)
                    for (int b = 0; b < 8; b++) begin
                        code = tb_buf[r * COLS + c];
                        a    = {code[6:0], 4'(s), 3'(b)};
                        p    = font_bit(a) ^ (INV_EN & code[7]);
                        eol  = (c == COLS - 1) && (b == 7);
                        last = eol && (s == 15) && (r == ROWS - 1);
                        exp_q.push_back({p, eol, last});
                    end
    endtask

    task automatic write_cell(input int addr, input logic [7:0] data);
        @(posedge clk);
        #1;
        txt_we   = 1'b1;
        txt_addr = 6'(addr);
        txt_data = data;
        tb_buf[addr] = data;
        @(posedge clk);
        #1;
        txt_we = 1'b0;
    endtask

    task automatic start_frame();
        push_frame();
        px_cnt    = 0;
        first_cyc = -1;
        mon_en    = 1'b1;
        u_if.pix_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("lat_busy", busy, 1);
        check("lat_valid0", u_if.pix_valid, 0);
        @(negedge clk);
        check("lat_valid1", u_if.pix_valid, 1);
    endtask

    task automatic run_frame(input int start_at, input int stall_at, input bit rnd, input bit chk_tp);
        int  fd0;
        bit  restarted, stalled;
        logic       s_pix;
        logic [13:0] s_ad;
        fd0       = fd_cnt;
        restarted = 1'b0;
        stalled   = 1'b0;
        start_frame();
        for (int n = 0; n < 40000 && fd_cnt == fd0; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (rnd) u_if.pix_ready = 1'($urandom_range(0, 1));
            if (start_at > 0 && !restarted && px_cnt >= start_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (stall_at > 0 && !stalled && px_cnt >= stall_at) begin
                stalled = 1'b1;
                u_if.pix_ready = 1'b0;
                @(negedge clk);
                s_pix = u_if.pix;
                s_ad  = u_if.font_ad;
                check("stall_ce", u_if.font_ce, 0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("stall_pix", u_if.pix, s_pix);
                    check("stall_valid", u_if.pix_valid, 1);
                    check("stall_ad", u_if.font_ad, s_ad);
                    check("stall_ce", u_if.font_ce, 0);
                end
                @(posedge clk);
                #1 u_if.pix_ready = 1'b1;
            end
        end
        check("frame_timeout", fd_cnt, fd0 + 1);
        u_if.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fd_count", fd_cnt, fd0 + 1);
        check("px_count", px_cnt, FRAME_PX);
        check("queue_empty", exp_q.size(), 0);
        check("busy_after", busy, 0);
        if (chk_tp) check("throughput", fd_cyc - first_cyc, FRAME_PX);
        mon_en = 1'b0;
    endtask

    initial begin
        int fd0;
        u_if.pix_ready = 1'b1;
        for (int i = 0; i < CELLS; i++) tb_buf[i] = 8'h20;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_valid", u_if.pix_valid, 0);
        check("rst_eol", u_if.pix_eol, 0);
        check("rst_last", u_if.pix_last, 0);
        check("rst_ce", u_if.font_ce, 0);
        check("rst_ad", u_if.font_ad, 0);
        check("rst_oce", u_if.font_oce, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        run_frame(0, 0, 1'b0, 1'b1);                 // blank screen
        write_cell(0, 8'h41);
        run_frame(0, 0, 1'b0, 1'b1);                 // glyph in cell 0
        run_frame(100, 500, 1'b0, 1'b0);             // ignored start + stall
        write_cell(17, 8'h5A);
        write_cell(63, 8'h7E);
        write_cell(5, 8'h23);
        run_frame(0, 0, 1'b1, 1'b0);                 // random back-pressure
        write_cell(0, 8'hC1);
        run_frame(0, 0, 1'b0, 1'b1);                 // inverse flag

        // Abort mid-frame with reset.
        fd0 = fd_cnt;
        start_frame();
        for (int n = 0; n < 20000 && px_cnt < 3000; n++) @(posedge clk);
        check("abort_reach", px_cnt, 3000);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", u_if.pix_valid, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_fd", fd_cnt, fd0);
        for (int i = 0; i < CELLS; i++) tb_buf[i] = 8'h20;
        run_frame(0, 0, 1'b0, 1'b1);                 // buffer cleared by reset

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
